seq_add_sub: RTL and testbench

- Parametrised multi-cycle two's-complement adder/subtractor.
- Processes CHUNK bits per clock from LSB to MSB, so wide operands are handled without a full-width ripple path.
- Successor to the combinational 32-bit subtractor: adds add/sub mode select, a start/done handshake and status flags.
- Sits on the datapath as a shared arithmetic unit driven by the lab controller FSM.

---
 rtl/seq_add_sub.sv | 187 ++++++++++++++++++
 tb/tb_seq_add_sub.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/seq_add_sub.sv
// seq_add_sub: multi-cycle two's-complement adder/subtractor.
//
// Adds (sub=0) or subtracts (sub=1) WIDTH-bit operands CHUNK bits per clock,
// LSB chunk first, so the carry chain per cycle is only CHUNK+1 bits long.
// The result and the flags are published together with a one-cycle done pulse.
//
// Optional feature macro: SEQ_ADD_SUB_FLAGS_EN
//   defined   : ovf (signed overflow) and zero (s == 0) are computed and
//               registered at completion.
//   undefined : ovf and zero are tied to 0 and their logic is not built.
//
// Ports:
//   clk   in   rising-edge clock
//   rst   in   synchronous active-high reset (aborts any operation)
//   start in   request, accepted only while busy=0
//   sub   in   0: s = a + b + cin, 1: s = a + ~b + cin
//   a, b  in   operands, latched on an accepted start
//   cin   in   carry into bit 0, latched on an accepted start
//   busy  out  operation in progress
//   done  out  one-cycle pulse when s/cout/flags update
//   s     out  result, held until the next completion
//   cout  out  carry out of the MSB (sub mode: 1 = no borrow)
//   ovf   out  signed overflow
//   zero  out  s == 0

module seq_add_sub #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int IW = $clog2(WIDTH) + 1;

  // Reject parameter sets that would leave a partial chunk.
  generate
    if ((CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_bad_params
      $error("seq_add_sub: WIDTH must be a positive multiple of CHUNK");
    end
  endgenerate

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;       // already inverted in sub mode
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] res_q, res_d;   // partial result being assembled
  logic [WIDTH-1:0] s_q, s_d;
  logic             cout_q, cout_d;
  logic             done_q, done_d;

  // Current chunk datapath.
  logic [IW-1:0]    base;
  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK:0]   sum_ext;
  logic [WIDTH-1:0] res_ins;
  logic             last_chunk;

  always_comb begin
    base       = IW'(cnt_q) * IW'(CHUNK);
    a_chunk    = CHUNK'(a_q >> base);
    b_chunk    = CHUNK'(b_q >> base);
    sum_ext    = {1'b0, a_chunk} + {1'b0, b_chunk} + (CHUNK+1)'(carry_q);
    res_ins    = (res_q & ~(WIDTH'({CHUNK{1'b1}}) << base))
               | (WIDTH'(sum_ext[CHUNK-1:0]) << base);
    last_chunk = (cnt_q == CW'(N - 1));
  end

`ifdef SEQ_ADD_SUB_FLAGS_EN
  logic ovf_q, ovf_d;
  logic zero_q, zero_d;
  logic msb_cin;

  // Carry into the MSB recovered from the MSB sum bit of the final chunk.
  assign msb_cin = a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ sum_ext[CHUNK-1];

  always_comb begin
    ovf_d  = ovf_q;
    zero_d = zero_q;
    if ((state_q == RUN) && last_chunk) begin
      ovf_d  = msb_cin ^ sum_ext[CHUNK];
      zero_d = (res_ins == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
    end
  end

  assign ovf  = ovf_q;
  assign zero = zero_q;
`else
  assign ovf  = 1'b0;
  assign zero = 1'b0;
`endif

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    s_d     = s_q;
    cout_d  = cout_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = cin;
          cnt_d   = '0;
          res_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        res_d   = res_ins;
        carry_d = sum_ext[CHUNK];
        cnt_d   = cnt_q + CW'(1);
        if (last_chunk) begin
          cnt_d   = '0;
          s_d     = res_ins;
          cout_d  = sum_ext[CHUNK];
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = done_q;
  assign s    = s_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_seq_add_sub.sv
module tb_seq_add_sub;

`ifdef SEQ_ADD_SUB_FLAGS_EN
  localparam bit FLAGS_EN = 1'b1;
`else
  localparam bit FLAGS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start_v [3];
  logic        sub;
  logic [31:0] a, b;
  logic        cin;
  logic        busy_v [3];
  logic        done_v [3];
  logic [31:0] s_v    [3];
  logic        cout_v [3];
  logic        ovf_v  [3];
  logic        zero_v [3];

  int pass_cnt  = 0;
  int total_cnt = 0;
  int lat_exp [3] = '{4, 32, 1};

  always #5 clk = ~clk;

  seq_add_sub #(.WIDTH(32), .CHUNK(8)) dut8 (
    .clk(clk), .rst(rst), .start(start_v[0]), .sub(sub), .a(a), .b(b), .cin(cin),
    .busy(busy_v[0]), .done(done_v[0]), .s(s_v[0]), .cout(cout_v[0]),
    .ovf(ovf_v[0]), .zero(zero_v[0]));

  seq_add_sub #(.WIDTH(32), .CHUNK(1)) dut1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .sub(sub), .a(a), .b(b), .cin(cin),
    .busy(busy_v[1]), .done(done_v[1]), .s(s_v[1]), .cout(cout_v[1]),
    .ovf(ovf_v[1]), .zero(zero_v[1]));

  seq_add_sub #(.WIDTH(32), .CHUNK(32)) dut32 (
    .clk(clk), .rst(rst), .start(start_v[2]), .sub(sub), .a(a), .b(b), .cin(cin),
    .busy(busy_v[2]), .done(done_v[2]), .s(s_v[2]), .cout(cout_v[2]),
    .ovf(ovf_v[2]), .zero(zero_v[2]));

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic        cin;
    logic [31:0] exp_s;
    logic        exp_cout;
    logic        exp_ovf;
    logic        exp_zero;
  } vec_t;

  vec_t vecs [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Launch one operation on instance d from the current cycle and follow it
  // to completion. poke>0 asserts a junk start in RUN cycle poke.
  task automatic run_op(input int d, input vec_t v, input int poke);
    logic [31:0] s_before;
    bit          seen;
    bit          held;
    int          lat;
    s_before = s_v[d];
    a = v.a; b = v.b; sub = v.sub; cin = v.cin;
    start_v[d] = 1'b1;
    tick();
    start_v[d] = 1'b0;
    check("busy_after_start", busy_v[d], 1'b1);
    seen = 0; held = 1; lat = 0;
    for (int k = 1; k <= 64 && !seen; k++) begin
      if (poke > 0 && k == poke + 1) begin
        a = 32'h0; b = 32'h0; sub = 1'b0; cin = 1'b0;
        start_v[d] = 1'b1;
      end else begin
        start_v[d] = 1'b0;
      end
      tick();
      if (done_v[d]) begin
        seen = 1; lat = k;
      end else if (s_v[d] !== s_before) begin
        held = 0;
      end
    end
    start_v[d] = 1'b0;
    check("done_seen", seen, 1'b1);
    check("latency", lat, lat_exp[d]);
    check("s_held_in_run", held, 1'b1);
    check("busy_at_done", busy_v[d], 1'b0);
    check("s", s_v[d], v.exp_s);
    check("cout", cout_v[d], v.exp_cout);
    check("ovf", ovf_v[d], v.exp_ovf & FLAGS_EN);
    check("zero", zero_v[d], v.exp_zero & FLAGS_EN);
    $display("op inst=%0d a=%h b=%h sub=%0d cin=%0d -> s=%h cout=%0d ovf=%0d zero=%0d lat=%0d",
             d, v.a, v.b, v.sub, v.cin, s_v[d], cout_v[d], ovf_v[d], zero_v[d], lat);
  endtask

  initial begin
    vec_t v2;
    bit   done_any;

    vecs[0] = '{32'hAAAAAAAA, 32'h55555555, 1'b1, 1'b1, 32'h55555555, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{32'h00000005, 32'h00000007, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{32'h12345678, 32'h11111111, 1'b0, 1'b1, 32'h2345678A, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{32'h80000000, 32'h00000001, 1'b1, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{32'h00000000, 32'h00000000, 1'b1, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1};
    vecs[7] = '{32'h0000000A, 32'h00000003, 1'b1, 1'b0, 32'h00000006, 1'b1, 1'b0, 1'b0};

    rst = 1'b1;
    for (int i = 0; i < 3; i++) start_v[i] = 1'b0;
    a = '0; b = '0; sub = 1'b0; cin = 1'b0;
    tick(); tick();
    start_v[0] = 1'b1;   // reset must win over start
    tick();
    start_v[0] = 1'b0;
    rst = 1'b0;
    check("rst_busy", busy_v[0], 1'b0);
    check("rst_done", done_v[0], 1'b0);
    check("rst_s", s_v[0], 32'h0);
    check("rst_cout", cout_v[0], 1'b0);
    check("rst_ovf", ovf_v[0], 1'b0);
    check("rst_zero", zero_v[0], 1'b0);
    tick();

    // Directed vector table on the CHUNK=8 instance.
    for (int i = 0; i < 8; i++) begin
      run_op(0, vecs[i], 0);
      tick();
      check("done_one_cycle", done_v[0], 1'b0);
    end

    // Back-to-back: second start driven while done is high.
    run_op(0, vecs[3], 0);
    check("b2b_done_high", done_v[0], 1'b1);
    v2 = '{32'h00000003, 32'h00000004, 1'b0, 1'b0, 32'h00000007, 1'b0, 1'b0, 1'b0};
    run_op(0, v2, 0);
    tick();

    // Start while busy in RUN cycle 2 must be ignored.
    run_op(0, vecs[0], 2);
    tick(); tick();

    // Reset in RUN cycle 2 aborts with no done pulse.
    a = 32'h12345678; b = 32'h1; sub = 1'b0; cin = 1'b0;
    start_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", busy_v[0], 1'b0);
    check("abort_s", s_v[0], 32'h0);
    done_any = 0;
    for (int k = 0; k < 8; k++) begin
      if (done_v[0]) done_any = 1;
      tick();
    end
    check("abort_no_done", done_any, 1'b0);
    check("abort_s_after", s_v[0], 32'h0);
    $display("op inst=0 reset mid-run -> busy=%0d s=%h", busy_v[0], s_v[0]);

    // Bit-serial and single-cycle builds.
    run_op(1, vecs[0], 0);
    tick();
    run_op(2, vecs[0], 0);
    tick();
    check("c32_done_one_cycle", done_v[2], 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
